// File: rtl/alu_muldiv_seq_pkg.sv
// Shared op codes and helpers for the iterative multiply/divide unit.
// Op bit 1 selects divide, bit 0 selects signed operation.
package alu_muldiv_seq_pkg;

   typedef enum logic [1:0] {
      MD_MULU = 2'b00,
      MD_MULS = 2'b01,
      MD_DIVU = 2'b10,
      MD_DIVS = 2'b11
   } md_op_e;

   function automatic logic md_is_div(input md_op_e op);
      return op[1];
   endfunction

   function automatic logic md_is_signed(input md_op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// trial-subtract for divide, on the {hi,lo} accumulator pair.
module alu_muldiv_seq_step #(
   parameter int WIDTH = 32
) (
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_rs;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;

   assign w_add  = i_lo[0] ? ({1'b0, i_hi} + {1'b0, i_d})
                           : {1'b0, i_hi};
   assign w_rs   = {i_hi, i_lo[WIDTH-1]};
   // rem < divisor, so a committed difference always fits WIDTH bits
   assign w_ge   = (w_rs >= {1'b0, i_d});
   assign w_diff = w_rs[WIDTH-1:0] - i_d;

   always_comb begin
      o_hi = w_add[WIDTH:1];
      o_lo = {w_add[0], i_lo[WIDTH-1:1]};
      if (i_div) begin
         o_hi = w_ge ? w_diff : w_rs[WIDTH-1:0];
         o_lo = {i_lo[WIDTH-2:0], w_ge};
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide unit: fixed WIDTH+2 cycle latency,
// HI/LO results (product halves, or remainder/quotient).
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_hi,
   output logic [WIDTH-1:0] out_lo,
   output logic             out_z,
   output logic             out_dbz
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE
   } state_e;

   state_e             r_state, w_next;
   md_op_e             r_op;
   logic [WIDTH-1:0]   r_a, r_b, r_md;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_rsign, r_asign, r_dbz;
   logic [WIDTH-1:0]   r_out_hi, r_out_lo;
   logic               r_out_z, r_out_dbz;

   logic               w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH-1:0]   w_step_hi, w_step_lo;
   logic [2*WIDTH-1:0] w_nprod;
   logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_PREP;
         end
         S_PREP: w_next = S_RUN;
         S_RUN: if (r_cnt == CNT_W'(1)) w_next = S_FIX;
         S_FIX: w_next = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_a_neg = md_is_signed(r_op) & r_a[WIDTH-1];
   assign w_b_neg = md_is_signed(r_op) & r_b[WIDTH-1];
   // MIN negates to itself, which is the correct unsigned magnitude
   assign w_a_mag = w_a_neg ? -r_a : r_a;
   assign w_b_mag = w_b_neg ? -r_b : r_b;

   alu_muldiv_seq_step #(.WIDTH(WIDTH)) u_step (
      .i_div (md_is_div(r_op)),
      .i_hi  (r_hi),
      .i_lo  (r_lo),
      .i_d   (r_md),
      .o_hi  (w_step_hi),
      .o_lo  (w_step_lo)
   );

   assign w_nprod = -{r_hi, r_lo};

   always_comb begin
      w_fix_hi = r_hi;
      w_fix_lo = r_lo;
      if (r_dbz) begin
         w_fix_hi = r_a;
         w_fix_lo = '1;
      end else if (r_op == MD_MULS) begin
         if (r_rsign) {w_fix_hi, w_fix_lo} = w_nprod;
      end else if (r_op == MD_DIVS) begin
         if (r_rsign) w_fix_lo = -r_lo;
         if (r_asign) w_fix_hi = -r_hi;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op      <= MD_MULU;
         r_a       <= '0;
         r_b       <= '0;
         r_md      <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_rsign   <= 1'b0;
         r_asign   <= 1'b0;
         r_dbz     <= 1'b0;
         r_out_hi  <= '0;
         r_out_lo  <= '0;
         r_out_z   <= 1'b1;
         r_out_dbz <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: if (in_valid) begin
               r_op <= md_op_e'(in_op);
               r_a  <= in_a;
               r_b  <= in_b;
            end
            S_PREP: begin
               r_md    <= md_is_div(r_op) ? w_b_mag : w_a_mag;
               r_lo    <= md_is_div(r_op) ? w_a_mag : w_b_mag;
               r_hi    <= '0;
               r_cnt   <= CNT_W'(WIDTH);
               r_rsign <= w_a_neg ^ w_b_neg;
               r_asign <= w_a_neg;
               r_dbz   <= md_is_div(r_op) && (r_b == '0);
            end
            S_RUN: begin
               r_hi  <= w_step_hi;
               r_lo  <= w_step_lo;
               r_cnt <= r_cnt - CNT_W'(1);
            end
            S_FIX: begin
               r_out_hi  <= w_fix_hi;
               r_out_lo  <= w_fix_lo;
               r_out_z   <= ({w_fix_hi, w_fix_lo} == '0);
               r_out_dbz <= r_dbz;
            end
            S_DONE: ;
            default: ;
         endcase
      end
   end

   assign out_hi  = r_out_hi;
   assign out_lo  = r_out_lo;
   assign out_z   = r_out_z;
   assign out_dbz = r_out_dbz;

endmodule
